// File: rtl/can_fd_inj_pkg.sv
// Shared types and constants for the CAN FD bit injector.
// STUFF state exists only when CAN_FD_INJ_STUFF_EN is defined.
package can_fd_inj_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MIN_BT    = 2;
  localparam int unsigned STUFF_RUN = 5;
  localparam int unsigned RUN_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIT   = 2'd1,
`ifdef CAN_FD_INJ_STUFF_EN
    ST_STUFF = 2'd2,
`endif
    ST_DONE  = 2'd3
  } t_inj_state;

endpackage

// File: rtl/can_fd_inj_buf.sv
// Word-organised frame buffer: appends 32-bit words, serves single bits MSB-first,
// reads past the loaded length return recessive. Used by can_fd_bit_injector.
module can_fd_inj_buf
  import can_fd_inj_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LEN_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [LEN_W-1:0]  rd_idx_i,
  output logic              rd_bit_c,
  output logic              full_o
);

  localparam int unsigned NWORDS = DEPTH / WORD_W;
  localparam int unsigned PTR_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned SEL_W  = $clog2(WORD_W);

  logic [WORD_W-1:0] mem_q [NWORDS];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [LEN_W-1:0]  loaded_q;
  logic [LEN_W-1:0]  loaded_inc;
  logic              wr_acc;
  logic [WORD_W-1:0] rd_word;
  logic [SEL_W-1:0]  rd_sel;

  assign wr_acc     = wr_en_i && !full_o && !clr_i;
  assign loaded_inc = loaded_q + LEN_W'(WORD_W);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      loaded_q <= '0;
      full_o   <= 1'b0;
    end else if (wr_acc) begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      loaded_q <= loaded_inc;
      full_o   <= (loaded_inc == LEN_W'(DEPTH));
    end
  end

  // Storage needs no reset: anything beyond loaded_q is masked on read.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Bit 31 of each word goes out first, hence the inverted select.
  assign rd_word  = mem_q[PTR_W'(rd_idx_i >> SEL_W)];
  assign rd_sel   = rd_idx_i[SEL_W-1:0];
  assign rd_bit_c = (rd_idx_i < loaded_q) ? rd_word[~rd_sel] : 1'b1;

endmodule

// File: rtl/can_fd_bit_injector.sv
// Dual-rate CAN FD bit-stream injector: serialises the loaded buffer at nominal/data rate.
// Define CAN_FD_INJ_STUFF_EN to insert stuff bits in hardware; otherwise the buffer is sent verbatim.
module can_fd_bit_injector
  import can_fd_inj_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned BT_W  = 16,
  parameter int unsigned LEN_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BT_W-1:0]   cfg_nbt_i,
  input  logic [BT_W-1:0]   cfg_dbt_i,
  input  logic              wr_en_i,
  input  logic [WORD_W-1:0] wr_data_i,
  output logic              wr_full_o,
  output logic              wr_ovf_o,
  input  logic [LEN_W-1:0]  frame_len_i,
  input  logic [LEN_W-1:0]  brs_start_i,
  input  logic [LEN_W-1:0]  brs_end_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  bit_idx_o,
  output logic              tx_o
);

  t_inj_state       state_q, state_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [LEN_W-1:0] brs_s_q, brs_s_d;
  logic [LEN_W-1:0] brs_e_q, brs_e_d;
  logic [LEN_W-1:0] bit_idx_q, bit_idx_d, idx_inc, bit_idx_c;
  logic [BT_W-1:0]  nbt_q, nbt_d, dbt_q, dbt_d;
  logic [BT_W-1:0]  bt_cnt_q, bt_cnt_d, bit_dur;
  logic             ovf_d, tx_c, busy_c, done_c;
  logic             in_win, bit_last;
  logic             buf_clr, buf_we, buf_full, rd_bit;
`ifdef CAN_FD_INJ_STUFF_EN
  logic [RUN_W-1:0] run_q, run_d, run_next;
  logic             last_q, last_d;
  logic             stuff_val_q, stuff_val_d;
`endif

  can_fd_inj_buf #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (buf_clr),
    .wr_en_i   (buf_we),
    .wr_data_i (wr_data_i),
    .rd_idx_i  (bit_idx_q),
    .rd_bit_c  (rd_bit),
    .full_o    (buf_full)
  );

  assign wr_full_o = buf_full;

  // Stuff bits keep bit_idx_q of the bit they follow, so they inherit its rate.
  assign in_win   = (bit_idx_q >= brs_s_q) && (bit_idx_q < brs_e_q);
  assign bit_dur  = in_win ? dbt_q : nbt_q;
  assign bit_last = (bt_cnt_q == bit_dur - BT_W'(1));
  assign idx_inc  = bit_idx_q + LEN_W'(1);
`ifdef CAN_FD_INJ_STUFF_EN
  assign run_next = ((run_q != '0) && (rd_bit == last_q)) ? run_q + RUN_W'(1) : RUN_W'(1);
`endif

  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    brs_s_d     = brs_s_q;
    brs_e_d     = brs_e_q;
    nbt_d       = nbt_q;
    dbt_d       = dbt_q;
    bit_idx_d   = bit_idx_q;
    bt_cnt_d    = bt_cnt_q;
    ovf_d       = wr_ovf_o;
    buf_clr     = 1'b0;
    buf_we      = 1'b0;
    tx_c        = 1'b1;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    bit_idx_c   = '0;
`ifdef CAN_FD_INJ_STUFF_EN
    run_d       = run_q;
    last_d      = last_q;
    stuff_val_d = stuff_val_q;
`endif
    if (abort_i) begin
      state_d = ST_IDLE;
      buf_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          buf_we = wr_en_i && !buf_full;
          if (start_i) begin
            ovf_d       = 1'b0;
            frame_len_d = (frame_len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : frame_len_i;
            brs_s_d     = brs_start_i;
            brs_e_d     = brs_end_i;
            nbt_d       = (cfg_nbt_i < BT_W'(MIN_BT)) ? BT_W'(MIN_BT) : cfg_nbt_i;
            dbt_d       = (cfg_dbt_i < BT_W'(MIN_BT)) ? BT_W'(MIN_BT) : cfg_dbt_i;
            bit_idx_d   = '0;
            bt_cnt_d    = '0;
`ifdef CAN_FD_INJ_STUFF_EN
            run_d       = '0;
`endif
            state_d     = (frame_len_i == '0) ? ST_DONE : ST_BIT;
          end
          if (wr_en_i && buf_full) begin
            ovf_d = 1'b1;
          end
        end
        ST_BIT: begin
          tx_c      = rd_bit;
          busy_c    = 1'b1;
          bit_idx_c = bit_idx_q;
          bt_cnt_d  = bt_cnt_q + BT_W'(1);
          if (wr_en_i) begin
            ovf_d = 1'b1;
          end
          if (bit_last) begin
            bt_cnt_d  = '0;
            bit_idx_d = idx_inc;
`ifdef CAN_FD_INJ_STUFF_EN
            run_d     = run_next;
            last_d    = rd_bit;
`endif
            if (idx_inc == frame_len_q) begin
              state_d = ST_DONE;
            end
`ifdef CAN_FD_INJ_STUFF_EN
            else if ((run_next == RUN_W'(STUFF_RUN)) && (bit_idx_q < brs_e_q)) begin
              state_d     = ST_STUFF;
              bit_idx_d   = bit_idx_q;
              stuff_val_d = ~rd_bit;
            end
`endif
          end
        end
`ifdef CAN_FD_INJ_STUFF_EN
        ST_STUFF: begin
          tx_c      = stuff_val_q;
          busy_c    = 1'b1;
          bit_idx_c = bit_idx_q;
          bt_cnt_d  = bt_cnt_q + BT_W'(1);
          if (wr_en_i) begin
            ovf_d = 1'b1;
          end
          // The stuff bit opens the next equal-run.
          if (bit_last) begin
            bt_cnt_d  = '0;
            bit_idx_d = idx_inc;
            run_d     = RUN_W'(1);
            last_d    = stuff_val_q;
            state_d   = ST_BIT;
          end
        end
`endif
        ST_DONE: begin
          done_c  = 1'b1;
          buf_clr = 1'b1;
          state_d = ST_IDLE;
          if (wr_en_i) begin
            ovf_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      frame_len_q <= '0;
      brs_s_q     <= '0;
      brs_e_q     <= '0;
      nbt_q       <= '0;
      dbt_q       <= '0;
      bit_idx_q   <= '0;
      bt_cnt_q    <= '0;
      wr_ovf_o    <= 1'b0;
      tx_o        <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      bit_idx_o   <= '0;
`ifdef CAN_FD_INJ_STUFF_EN
      run_q       <= '0;
      last_q      <= 1'b0;
      stuff_val_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      frame_len_q <= frame_len_d;
      brs_s_q     <= brs_s_d;
      brs_e_q     <= brs_e_d;
      nbt_q       <= nbt_d;
      dbt_q       <= dbt_d;
      bit_idx_q   <= bit_idx_d;
      bt_cnt_q    <= bt_cnt_d;
      wr_ovf_o    <= ovf_d;
      tx_o        <= tx_c;
      busy_o      <= busy_c;
      done_o      <= done_c;
      bit_idx_o   <= bit_idx_c;
`ifdef CAN_FD_INJ_STUFF_EN
      run_q       <= run_d;
      last_q      <= last_d;
      stuff_val_q <= stuff_val_d;
`endif
    end
  end

endmodule

// File: tb/tb_can_fd_bit_injector.sv
// Randomised bench for can_fd_bit_injector against a per-cycle line model.
// Honours CAN_FD_INJ_STUFF_EN in the model when the design is built with it.
module tb_can_fd_bit_injector;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned BT_W  = 16;
  localparam int unsigned LEN_W = $clog2(DEPTH + 1);
  localparam int unsigned NW    = DEPTH / 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [BT_W-1:0]  cfg_nbt, cfg_dbt;
  logic             wr_en;
  logic [31:0]      wr_data;
  logic             wr_full, wr_ovf;
  logic [LEN_W-1:0] frame_len, brs_start, brs_end, bit_idx;
  logic             start, abort, busy, done, tx;

  always #5 clk = ~clk;

  can_fd_bit_injector #(
    .DEPTH (DEPTH),
    .BT_W  (BT_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_nbt_i   (cfg_nbt),
    .cfg_dbt_i   (cfg_dbt),
    .wr_en_i     (wr_en),
    .wr_data_i   (wr_data),
    .wr_full_o   (wr_full),
    .wr_ovf_o    (wr_ovf),
    .frame_len_i (frame_len),
    .brs_start_i (brs_start),
    .brs_end_i   (brs_end),
    .start_i     (start),
    .abort_i     (abort),
    .busy_o      (busy),
    .done_o      (done),
    .bit_idx_o   (bit_idx),
    .tx_o        (tx)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mwords [NW];
  int          mloaded  = 0;
  logic        movf     = 1'b0;
  int          exp_v[$];
  int          exp_i[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void mdl_write(input logic [31:0] w);
    if (mloaded < int'(DEPTH)) begin
      mwords[mloaded / 32] = w;
      mloaded += 32;
    end else begin
      movf = 1'b1;
    end
  endfunction

  // Expected line value and bit index for every cycle of the frame.
  function automatic void build(input int fl, input int bs, input int be, input int n, input int d);
`ifdef CAN_FD_INJ_STUFF_EN
    int run = 0;
    int lastv = 0;
`endif
    exp_v.delete();
    exp_i.delete();
    for (int i = 0; i < fl; i++) begin
      logic [31:0] w;
      int v, dur;
      w   = mwords[i / 32];
      v   = (i < mloaded) ? int'(w[31 - (i % 32)]) : 1;
      dur = (i >= bs && i < be) ? d : n;
      repeat (dur) begin exp_v.push_back(v); exp_i.push_back(i); end
`ifdef CAN_FD_INJ_STUFF_EN
      run   = (run != 0 && v == lastv) ? run + 1 : 1;
      lastv = v;
      if (i != fl - 1 && run == 5 && i < be) begin
        repeat (dur) begin exp_v.push_back(1 - v); exp_i.push_back(i); end
        run   = 1;
        lastv = 1 - v;
      end
`endif
    end
  endfunction

  // Entered and left just after a falling edge.
  task automatic wr_word(input logic [31:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en   = 1'b0;
    mdl_write(w);
  endtask

  task automatic run_frame(input int flen, input int bs, input int be, input int n, input int d,
                           input bit with_wr, input logic [31:0] ww);
    int fl, ne, de;
    fl   = (flen > int'(DEPTH)) ? int'(DEPTH) : flen;
    ne   = (n < 2) ? 2 : n;
    de   = (d < 2) ? 2 : d;
    movf = 1'b0;
    if (with_wr) begin
      mdl_write(ww);
      wr_en   = 1'b1;
      wr_data = ww;
    end
    build(fl, bs, be, ne, de);
    start     = 1'b1;
    frame_len = LEN_W'(flen);
    brs_start = LEN_W'(bs);
    brs_end   = LEN_W'(be);
    cfg_nbt   = BT_W'(n);
    cfg_dbt   = BT_W'(d);
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    chk("lat_tx", 32'(tx), 32'd1);
    chk("lat_busy", 32'(busy), 32'd0);
    chk("ovf_after_start", 32'(wr_ovf), 32'(movf));
    foreach (exp_v[j]) begin
      @(negedge clk);
      chk("tx", 32'(tx), 32'(exp_v[j]));
      chk("busy", 32'(busy), 32'd1);
      chk("bit_idx", 32'(bit_idx), 32'(exp_i[j]));
    end
    @(negedge clk);
    chk("done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_tx", 32'(tx), 32'd1);
    @(negedge clk);
    chk("done_off", 32'(done), 32'd0);
    chk("full_cleared", 32'(wr_full), 32'd0);
    mloaded = 0;
  endtask

  initial begin
    int   nw, seen_done, waited;
    bit   found;
    rst = 1'b1; cfg_nbt = '0; cfg_dbt = '0; wr_en = 1'b0; wr_data = '0;
    frame_len = '0; brs_start = '0; brs_end = '0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_full", 32'(wr_full), 32'd0);
    chk("rst_ovf", 32'(wr_ovf), 32'd0);
    chk("rst_idx", 32'(bit_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Alternating pattern at nominal rate.
    wr_word(32'hAAAA_AAAA);
    run_frame(32, 0, 0, 20, 20, 1'b0, '0);

    // Two words with a data-rate window.
    wr_word($urandom);
    wr_word($urandom);
    run_frame(64, 16, 48, 40, 10, 1'b0, '0);

    // All-dominant word (stuffing pattern when enabled).
    wr_word(32'h0000_0000);
    run_frame(12, 0, 12, 4, 4, 1'b0, '0);

    // Overfill: one word more than capacity.
    for (int k = 0; k < int'(NW) + 1; k++) begin
      wr_word($urandom);
      chk("full_flag", 32'(wr_full), 32'(mloaded == int'(DEPTH)));
      chk("ovf_flag", 32'(wr_ovf), 32'(movf));
    end
    run_frame(int'(DEPTH), 40, 90, 2, 3, 1'b0, '0);

    // Write in the same cycle as start is included.
    wr_word($urandom);
    run_frame(64, 0, 0, 3, 3, 1'b1, $urandom);

    // Recessive fill past loaded bits; zero-length frame.
    wr_word($urandom);
    run_frame(40, 8, 20, 3, 2, 1'b0, '0);
    run_frame(0, 0, 0, 5, 5, 1'b0, '0);

    // Busy write then abort at bit 7 of a full buffer.
    for (int k = 0; k < int'(NW); k++) wr_word($urandom);
    chk("abort_pre_full", 32'(wr_full), 32'd1);
    start = 1'b1; frame_len = LEN_W'(32); brs_start = '0; brs_end = '0;
    cfg_nbt = BT_W'(4); cfg_dbt = BT_W'(4);
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b1; wr_data = $urandom;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_busy_write", 32'(wr_ovf), 32'd1);
    found = 1'b0;
    waited = 0;
    while (!found && waited < 300) begin
      @(negedge clk);
      waited++;
      if (bit_idx == LEN_W'(7) && busy) found = 1'b1;
    end
    chk("abort_reach_bit7", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_full", 32'(wr_full), 32'd0);
    chk("ovf_sticky", 32'(wr_ovf), 32'd1);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    mloaded = 0;

    // Reset in the middle of a frame.
    wr_word(32'h0F0F_0F0F);
    start = 1'b1; frame_len = LEN_W'(32); cfg_nbt = BT_W'(5);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_idx", 32'(bit_idx), 32'd0);
    chk("midrst_ovf", 32'(wr_ovf), 32'd0);
    mloaded = 0;
    movf = 1'b0;
    @(negedge clk);

    // Random frames.
    for (int r = 0; r < 25; r++) begin
      nw = int'($urandom_range(0, NW));
      for (int k = 0; k < nw; k++) wr_word($urandom);
      run_frame(int'($urandom_range(0, DEPTH + 12)), int'($urandom_range(0, DEPTH + 4)),
                int'($urandom_range(0, DEPTH + 4)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
